// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: word and counter widths,
// the FSM state encoding and the captured-request payload.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request fields latched when a transaction is accepted
    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write, combinational read, no reset.
// Ports:
//   clk   - write clock
//   we    - write enable, sampled on the rising edge
//   addr  - word index shared by the read and write paths
//   wdata - word to store
//   rdata - word currently at addr
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [WORD_W-1:0]              wdata,
    output logic [WORD_W-1:0]              rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Contents survive reset on purpose
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, inserts WAIT_CYCLES wait
// states, then completes it with a one-cycle ready pulse (err flags a rejected
// access). Outputs are registered on the edge that ends RESP, so ready appears
// WAIT_CYCLES+1 cycles after the accepting edge.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   req          - access request, held with we/addr/wdata until ready
//   we           - 1 = store, 0 = load
//   addr         - byte address (must be word aligned and inside the array)
//   wdata        - store data
//   rdata        - load data, held until the next response
//   ready        - one-cycle completion pulse
//   err          - access rejected, qualifies ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    req_t               cap;

    logic               bad_c;
    logic [AW-1:0]      word_c;
    logic               mem_we_c;
    logic [WORD_W-1:0]  mem_rdata_c;

    // Reject misaligned or out-of-range accesses; range uses the full word index
    assign bad_c    = (cap.addr[1:0] != 2'b00) ||
                      (cap.addr[WORD_W-1:2] >= (WORD_W-2)'(DEPTH_WORDS));
    assign word_c   = cap.addr[AW+1:2];
    // Write lands on the edge that leaves RESP; reset drops state, blocking it
    assign mem_we_c = (state == RESP) && cap.we && !bad_c;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_c),
        .addr  (word_c),
        .wdata (cap.wdata),
        .rdata (mem_rdata_c)
    );

    // Control FSM with registered response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            cap   <= '0;
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        cap.we    <= we;
                        cap.addr  <= addr;
                        cap.wdata <= wdata;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    ready <= 1'b1;
                    err   <= bad_c;
                    if (bad_c) begin
                        rdata <= '0;
                    end else if (!cap.we) begin
                        rdata <= mem_rdata_c;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
